// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   state_t     : loader FSM states
//   HDR_BYTES   : bytes in the image header (big-endian word count)
//   WORD_BYTES  : bytes per instruction word
//   word_addr() : byte address of a word index relative to a base
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int HDR_BITS   = 8 * HDR_BYTES;
    localparam int WORD_BITS  = 8 * WORD_BYTES;

    // Address arithmetic is plain 32-bit and wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] index);
        return base + (index << 2);
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Byte-to-word assembler for the program loader.
//   CLK, rst  : clock, asynchronous active-low reset
//   clear     : zero the shift register and byte counter
//   shift     : accept data this cycle
//   data      : incoming stream byte (enters at [7:0], older bytes move up)
//   word      : assembled word, MSB = first byte of the group
//   word_full : this cycle's shift supplies the last byte of a word
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift,
    input  logic [7:0]           data,
    output logic [WORD_BITS-1:0] word,
    output logic                 word_full
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            word <= '0;
            cnt  <= '0;
        end else if (clear) begin
            word <= '0;
            cnt  <= '0;
        end else if (shift) begin
            word <= {word[WORD_BITS-9:0], data};
            // Wraps to zero on the last byte, so the next word starts clean
            // without an explicit clear from the FSM.
            cnt  <= cnt + 1'b1;
        end
    end

    // Combinational so the FSM can enter WRITE on the same edge that
    // captures the final byte; the register view would be a cycle late.
    assign word_full = shift && (cnt == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader in front of the core's unified memory.
// Consumes a byte stream (16-bit big-endian word count, then that many
// big-endian 32-bit words), writes each word to MEM through the ld_* port
// and holds the core in reset until the whole image has landed. The system
// level selects ld_we/ld_addr/ld_wd onto MEM's write port while core_rst=1.
//   CLK, rst      : clock, asynchronous active-low reset
//   start         : one-cycle pulse, begins a load from IDLE/DONE/ERR
//   byte_valid    : byte_data holds a stream byte
//   byte_data     : stream byte
//   byte_ready    : loader takes a byte this cycle (registered)
//   ld_we         : MEM write strobe, one cycle per word
//   ld_addr       : MEM byte address, BASE + 4*index
//   ld_wd         : MEM write data
//   core_rst      : active-high reset to the core
//   busy          : load in progress
//   done          : image loaded, core released
//   err           : header count exceeded DEPTH
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          DEPTH = 64,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        ld_we,
    output logic [31:0] ld_addr,
    output logic [31:0] ld_wd,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int                IDX_W = $clog2(DEPTH) + 1;
    localparam logic [HDR_BITS-1:0] MAX_N = HDR_BITS'(DEPTH);

    state_t                state;
    logic [IDX_W-1:0]      index;
    logic [HDR_BITS-1:0]   count;

    logic                  take;
    logic [HDR_BITS-1:0]   hdr_n;
    logic [IDX_W-1:0]      index_next;
    logic                  packer_clear;
    logic                  packer_shift;
    logic [WORD_BITS-1:0]  packed_word;
    logic                  word_full;

    assign take         = byte_valid && byte_ready;
    assign hdr_n        = {count[HDR_BITS-1:8], byte_data};
    assign index_next   = index + 1'b1;
    assign packer_clear = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign packer_shift = take && (state == S_DATA);

    byte_packer u_packer (
        .CLK       (CLK),
        .rst       (rst),
        .clear     (packer_clear),
        .shift     (packer_shift),
        .data      (byte_data),
        .word      (packed_word),
        .word_full (word_full)
    );

    // The shift register does not move during WRITE, so it is the write data.
    assign ld_wd = packed_word;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            index      <= '0;
            count      <= '0;
            byte_ready <= 1'b0;
            ld_we      <= 1'b0;
            ld_addr    <= BASE;
            core_rst   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all decisions see the
            // pre-edge values; outputs are set alongside the state they belong to.
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_HDR_HI;
                        index      <= '0;
                        count      <= '0;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        core_rst   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                S_HDR_HI: begin
                    if (take) begin
                        count[HDR_BITS-1:8] <= byte_data;
                        state               <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (take) begin
                        count <= hdr_n;
                        if (hdr_n == '0) begin
                            state      <= S_DONE;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            core_rst   <= 1'b0;
                        end else if (hdr_n > MAX_N) begin
                            state      <= S_ERR;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            err        <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (word_full) begin
                        state      <= S_WRITE;
                        byte_ready <= 1'b0;
                        ld_we      <= 1'b1;
                        ld_addr    <= word_addr(BASE, 32'(index));
                    end
                end
                S_WRITE: begin
                    ld_we <= 1'b0;
                    index <= index_next;
                    if (HDR_BITS'(index_next) == count) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        core_rst <= 1'b0;
                    end else begin
                        state      <= S_DATA;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. Two instances (BASE 0 and 0x100)
// share one stimulus stream; a stream-level model predicts every output.
module tb_prog_loader;

    localparam int          DEPTH  = 64;
    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'h0000_0100;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_data;

    logic        a_ready, a_we, a_core_rst, a_busy, a_done, a_err;
    logic [31:0] a_addr, a_wd;
    logic        b_ready, b_we, b_core_rst, b_busy, b_done, b_err;
    logic [31:0] b_addr, b_wd;

    always #5 clk = ~clk;

    prog_loader #(.DEPTH(DEPTH), .BASE(BASE_A)) dut_a (
        .CLK(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(a_ready), .ld_we(a_we),
        .ld_addr(a_addr), .ld_wd(a_wd), .core_rst(a_core_rst),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    prog_loader #(.DEPTH(DEPTH), .BASE(BASE_B)) dut_b (
        .CLK(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(b_ready), .ld_we(b_we),
        .ld_addr(b_addr), .ld_wd(b_wd), .core_rst(b_core_rst),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stream-level reference model ----------------
    typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mode_t;
    mode_t       m_mode = M_IDLE;
    int          m_taken = 0;   // bytes consumed since start
    int          m_n     = 0;   // header word count
    int          m_idx   = 0;   // words written so far
    bit          m_pend  = 0;   // a complete word is being written this cycle
    logic [31:0] m_acc   = '0;
    logic [31:0] m_word  = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = M_IDLE;
            m_pend = 0;
        end else begin
            case (m_mode)
                M_LOAD: begin
                    if (m_pend) begin
                        m_pend = 0;
                        m_idx++;
                        if (m_idx == m_n) m_mode = M_DONE;
                    end else if (byte_valid) begin
                        m_taken++;
                        m_acc = {m_acc[23:0], byte_data};
                        if (m_taken == 1) begin
                            m_n = int'(byte_data) * 256;
                        end else if (m_taken == 2) begin
                            m_n = m_n + int'(byte_data);
                            if (m_n == 0) m_mode = M_DONE;
                            else if (m_n > DEPTH) m_mode = M_ERR;
                        end else if ((m_taken - 2) % 4 == 0) begin
                            m_pend = 1;
                            m_word = m_acc;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        m_mode  = M_LOAD;
                        m_taken = 0;
                        m_idx   = 0;
                        m_pend  = 0;
                    end
                end
            endcase
        end
    end

    task automatic chk_port(input string t, input logic rdy, input logic we,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic crst, input logic bsy, input logic dn,
                            input logic er, input logic [31:0] base);
        check({t, ".byte_ready"}, 32'(rdy),  32'(m_mode == M_LOAD && !m_pend));
        check({t, ".ld_we"},      32'(we),   32'(m_pend));
        check({t, ".busy"},       32'(bsy),  32'(m_mode == M_LOAD));
        check({t, ".core_rst"},   32'(crst), 32'(m_mode != M_DONE));
        check({t, ".done"},       32'(dn),   32'(m_mode == M_DONE));
        check({t, ".err"},        32'(er),   32'(m_mode == M_ERR));
        if (m_pend) begin
            check({t, ".ld_addr"}, addr, base + 32'(m_idx) * 32'd4);
            check({t, ".ld_wd"},   wd,   m_word);
        end
    endtask

    logic [63:0] log_a[$];
    logic [63:0] log_b[$];

    always @(negedge clk) begin
        chk_port("a", a_ready, a_we, a_addr, a_wd, a_core_rst, a_busy, a_done, a_err, BASE_A);
        chk_port("b", b_ready, b_we, b_addr, b_wd, b_core_rst, b_busy, b_done, b_err, BASE_B);
        if (a_we) log_a.push_back({a_addr, a_wd});
        if (b_we) log_b.push_back({b_addr, b_wd});
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0]  stim[$];
    logic [31:0] img[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit   ok;
        logic rdy;
        if (gaps) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                byte_data = 8'($urandom);
                tick();
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            rdy = a_ready;
            tick();
            ok = rdy;
        end
        check("byte_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_range(input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) send_byte(stim[i], gaps);
        byte_valid = 1'b0;
    endtask

    task automatic build(input int n);
        stim.delete();
        stim.push_back(8'(n >> 8));
        stim.push_back(8'(n));
        foreach (img[i])
            for (int k = 3; k >= 0; k--) stim.push_back(img[i][8*k +: 8]);
    endtask

    task automatic reset_checks(input string t);
        check({t, " a.byte_ready"}, 32'(a_ready), 32'd0);
        check({t, " a.ld_we"},      32'(a_we),    32'd0);
        check({t, " a.ld_addr"},    a_addr,       BASE_A);
        check({t, " a.ld_wd"},      a_wd,         32'd0);
        check({t, " a.core_rst"},   32'(a_core_rst), 32'd1);
        check({t, " a.busy"},       32'(a_busy),  32'd0);
        check({t, " a.done"},       32'(a_done),  32'd0);
        check({t, " a.err"},        32'(a_err),   32'd0);
        check({t, " b.ld_addr"},    b_addr,       BASE_B);
        check({t, " b.ld_wd"},      b_wd,         32'd0);
    endtask

    task automatic check_image(input string t, input int s, input logic [31:0] base,
                               input bit use_b);
        for (int i = 0; i < img.size(); i++) begin
            logic [63:0] e;
            e = use_b ? log_b[s + i] : log_a[s + i];
            check($sformatf("%s addr[%0d]", t, i), e[63:32], base + 32'(i) * 32'd4);
            check($sformatf("%s data[%0d]", t, i), e[31:0], img[i]);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int s, s2;
        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) tick();
        reset_checks("por");
        rst = 1'b1;
        tick();

        // Two-word image; start arrives with a byte already valid.
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        pulse_start();
        check("t1 ready_after_start", 32'(a_ready), 32'd1);
        img = '{32'h2008_0005, 32'hAC08_0000};
        build(2);
        s = log_a.size();
        send_range(0, stim.size() - 1, 0);
        check("t1 we_last_write", 32'(a_we), 32'd1);
        check("t1 core_held",     32'(a_core_rst), 32'd1);
        tick();
        check("t1 core_released", 32'(a_core_rst), 32'd0);
        check("t1 done",          32'(a_done), 32'd1);
        check("t1 n_writes",      32'(log_a.size() - s), 32'd2);
        check("t1 w0 addr", log_a[s][63:32],   32'h0000_0000);
        check("t1 w0 data", log_a[s][31:0],    32'h2008_0005);
        check("t1 w1 addr", log_a[s+1][63:32], 32'h0000_0004);
        check("t1 w1 data", log_a[s+1][31:0],  32'hAC08_0000);
        check("t1 b w1 addr", log_b[s+1][63:32], 32'h0000_0104);

        // Empty image: header 00 00.
        pulse_start();
        check("t2 core_reheld", 32'(a_core_rst), 32'd1);
        check("t2 done_clear",  32'(a_done), 32'd0);
        s = log_a.size();
        stim = '{8'h00, 8'h00};
        send_range(0, 1, 0);
        check("t2 done",     32'(a_done), 32'd1);
        check("t2 core_rst", 32'(a_core_rst), 32'd0);
        tick();
        check("t2 no_writes", 32'(log_a.size() - s), 32'd0);

        // Oversized header 0x41 > DEPTH, then recovery.
        pulse_start();
        stim = '{8'h00, 8'h41};
        send_range(0, 1, 0);
        tick();
        check("t3 err",        32'(a_err), 32'd1);
        check("t3 core_rst",   32'(a_core_rst), 32'd1);
        check("t3 byte_ready", 32'(a_ready), 32'd0);
        pulse_start();
        img = '{32'h0123_4567, 32'h89AB_CDEF, 32'h0F1E_2D3C};
        build(3);
        s = log_a.size();
        send_range(0, stim.size() - 1, 0);
        repeat (2) tick();
        check("t3 recovered_done", 32'(a_done), 32'd1);
        check("t3 err_cleared",    32'(a_err), 32'd0);
        check_image("t3", s, BASE_A, 0);

        // Three random words, gap-free then with random gaps.
        img = '{$urandom, $urandom, $urandom};
        build(3);
        pulse_start();
        s = log_a.size();
        send_range(0, stim.size() - 1, 0);
        repeat (2) tick();
        check_image("t4 nogap", s, BASE_A, 0);
        pulse_start();
        s2 = log_a.size();
        send_range(0, stim.size() - 1, 1);
        repeat (2) tick();
        check("t4 gap n_writes", 32'(log_a.size() - s2), 32'd3);
        check_image("t4 gap", s2, BASE_A, 0);
        check_image("t4 gap b", s2, BASE_B, 1);

        // Reset after 6 of 8 data bytes.
        img = '{32'h1122_3344, 32'h5566_7788};
        build(2);
        pulse_start();
        s = log_a.size();
        send_range(0, 7, 0);
        #1;
        rst = 1'b0;
        #1;
        reset_checks("t5 midload");
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t5 partial_writes", 32'(log_a.size() - s), 32'd1);
        check("t5 w0 data", log_a[s][31:0], 32'h1122_3344);
        pulse_start();
        s = log_a.size();
        send_range(0, stim.size() - 1, 0);
        repeat (2) tick();
        check("t5 restart_done", 32'(a_done), 32'd1);
        check_image("t5 restart", s, BASE_A, 0);

        // One word at BASE 0x100 with a start pulse during DATA.
        img = '{32'hDEAD_BEEF};
        build(1);
        pulse_start();
        s = log_b.size();
        send_range(0, 3, 0);
        pulse_start();
        send_range(4, 5, 0);
        repeat (2) tick();
        check("t6 b n_writes", 32'(log_b.size() - s), 32'd1);
        check("t6 b addr", log_b[s][63:32], 32'h0000_0100);
        check("t6 b data", log_b[s][31:0],  32'hDEAD_BEEF);
        check("t6 b done", 32'(b_done), 32'd1);

        // Full-depth image (N == DEPTH).
        img.delete();
        for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
        build(DEPTH);
        pulse_start();
        s = log_a.size();
        send_range(0, stim.size() - 1, 0);
        repeat (2) tick();
        check("t7 done", 32'(a_done), 32'd1);
        check("t7 err",  32'(a_err), 32'd0);
        check("t7 n_writes", 32'(log_a.size() - s), 32'(DEPTH));
        check("t7 last addr", log_a[s + DEPTH - 1][63:32], 32'h0000_00FC);
        check_image("t7", s, BASE_B, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the multicycle core's unified memory. It accepts a byte stream (header word count plus big-endian instruction words), assembles 32-bit words and writes them into MEM through a dedicated write port, holding the core in reset until the image is complete. On success it releases the core; on a malformed header it keeps the core in reset and flags an error.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit words in MEM; maximum image length
- BASE, 32'h0000_0000, byte address of the first word written

Ports:
- CLK  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- ld_we  out  1  MEM write strobe, one cycle per word
- ld_addr  out  32  MEM byte address, BASE + 4*index
- ld_wd  out  32  MEM write data
- core_rst  out  1  active-high reset to the core's rst input
- busy  out  1  load in progress
- done  out  1  image loaded, core running
- err  out  1  header rejected

## Operation
- Stream format: count hi byte, count lo byte (16-bit N), then N words, 4 bytes each, MSB first.
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR.
- IDLE: byte_ready=0, core_rst=1. start -> HDR_HI, clears index, byte counter, count.
- HDR_HI: accept byte -> count[15:8], go HDR_LO.
- HDR_LO: accept byte -> count[7:0]. Full count N==0 -> DONE; N>DEPTH -> ERR; else DATA.
- DATA: accept bytes into a shift register (new byte enters [7:0], prior bits shift left 8). On 4th byte -> WRITE.
- WRITE: ld_we=1, ld_addr=BASE+4*index, ld_wd=assembled word; byte_ready=0. index+1; if new index==N -> DONE else DATA, byte counter cleared.
- DONE: core_rst=0, done=1. ERR: core_rst=1, err=1. start in either -> HDR_HI with core_rst=1 (core re-held).
- start while busy is ignored. Bytes presented when byte_ready=0 are not consumed (valid must hold).
- Address arithmetic 32-bit, wraps modulo 2^32; index width clog2(DEPTH)+1.

## Timing
- Reset values: byte_ready=0, ld_we=0, ld_addr=BASE, ld_wd=0, core_rst=1, busy=0, done=0, err=0; state IDLE.
- Byte transfer occurs on a rising edge with byte_valid && byte_ready. byte_ready is a registered function of state: 1 in HDR_HI, HDR_LO, DATA.
- Sustained throughput: 4 bytes in 4 cycles + 1 WRITE cycle per word; no back-pressure otherwise.
- ld_we asserted exactly one cycle, the cycle after the word's 4th byte is accepted; ld_addr/ld_wd stable in that cycle.
- core_rst falls in the first DONE cycle (cycle after last WRITE, or after HDR_LO when N==0); rises in the cycle after start is sampled in DONE/ERR.
- busy=1 in HDR_HI, HDR_LO, DATA, WRITE.
- Reset asserted mid-load: immediate return to IDLE, partial word discarded, ld_we deasserted, core_rst=1. Words already written stay in MEM.
- start coincident with byte_valid in IDLE: start taken, byte not consumed (byte_ready still 0).

## Structure
- Package prog_loader_pkg: state enum (7 states), HDR_BYTES=2, WORD_BYTES=4.
- Sub-module byte_packer: 32-bit shift register plus 2-bit byte counter, outputs word and word_full; loader FSM owns handshake, index and MEM port.
- In top level, ld_we/ld_addr/ld_wd muxed onto MEM's write port while core_rst=1.

## Test plan
- Reset, start, stream 00 02 | 20 08 00 05 | AC 08 00 00 -> ld_we twice: addr 0x0 data 0x20080005, addr 0x4 data 0xAC080000; core_rst falls the cycle after second write; done=1.
- Header 00 00 -> DONE directly after HDR_LO, no ld_we, core_rst=0.
- Header 00 41 with DEPTH=64 -> ERR, err=1, core_rst stays 1, byte_ready=0; subsequent start plus valid image -> loads and done=1.
- byte_valid toggled randomly (gaps) on 3-word image -> identical writes and addresses as gap-free run.
- rst pulled low after 6 of 8 data bytes -> outputs return to reset values asynchronously; only word 0 written; restart loads correctly.
- BASE=0x100, 1-word image DEADBEEF -> ld_addr=0x100, ld_wd=0xDEADBEEF; start pulse during DATA ignored.
